// File: rtl/misc_pkg.sv
// Shared pipeline definitions: datapath widths, ALU opcodes and the ID/EX record.
// The execute stage and the branch unit both import this package.
package misc_pkg;

  localparam int XLEN   = 16;
  localparam int RIDX_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              alu_src;
    logic [2:0]        alu_op;
    logic              mem_write;
    logic              mem_read;
    logic              reg_store;
    logic [XLEN-1:0]   opcp2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [RIDX_W-1:0] rs1_idx;
    logic [RIDX_W-1:0] rs2_idx;
    logic [RIDX_W-1:0] rd_idx;
    logic [XLEN-1:0]   imm;
  } idex_t;

  // A bubble carries no valid bit and no side-effecting control bits.
  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/execute_stage_alu16.sv
// 16-bit, 8-operation combinational ALU; shared with the branch unit.
module alu16
  import misc_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[3:0];
      ALU_SRL: y = a >> b[3:0];
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, forwarding muxes, load-use detection, ALU and
// the EX/MEM register feeding the Memory stage.
module execute_stage
  import misc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_op,
  input  logic              id_mem_write,
  input  logic              id_mem_read,
  input  logic              id_reg_store,
  input  logic [XLEN-1:0]   id_opcp2,
  input  logic [XLEN-1:0]   id_rs1_val,
  input  logic [XLEN-1:0]   id_rs2_val,
  input  logic [RIDX_W-1:0] id_rs1_idx,
  input  logic [RIDX_W-1:0] id_rs2_idx,
  input  logic [RIDX_W-1:0] id_rd_idx,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic              wb_rf_write,
  input  logic [RIDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_alu_result,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [RIDX_W-1:0] ex_rd_idx,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic [XLEN-1:0]   ex_opcp2
);

  idex_t idex_reg;
  idex_t idex_next;

  logic [RIDX_W-1:0] src_idx [2];
  logic [XLEN-1:0]   src_val [2];
  logic [XLEN-1:0]   fwd_val [2];
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_y;
  logic [XLEN-1:0]   result_next;

  always_comb begin
    idex_next           = IDEX_BUBBLE;
    idex_next.valid     = id_valid;
    idex_next.reg_write = id_reg_write;
    idex_next.alu_src   = id_alu_src;
    idex_next.alu_op    = id_alu_op;
    idex_next.mem_write = id_mem_write;
    idex_next.mem_read  = id_mem_read;
    idex_next.reg_store = id_reg_store;
    idex_next.opcp2     = id_opcp2;
    idex_next.rs1_val   = id_rs1_val;
    idex_next.rs2_val   = id_rs2_val;
    idex_next.rs1_idx   = id_rs1_idx;
    idex_next.rs2_idx   = id_rs2_idx;
    idex_next.rd_idx    = id_rd_idx;
    idex_next.imm       = id_imm;
  end

  assign src_idx[0] = idex_reg.rs1_idx;
  assign src_idx[1] = idex_reg.rs2_idx;
  assign src_val[0] = idex_reg.rs1_val;
  assign src_val[1] = idex_reg.rs2_val;

  // A load sitting in EX/MEM has no data yet, so it is skipped by the first rule.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_val[gi] = src_val[gi];
        if (src_idx[gi] == '0)
          fwd_val[gi] = '0;
        else if (ex_valid && ex_reg_write && !ex_mem_read && (ex_rd_idx == src_idx[gi]))
          fwd_val[gi] = ex_alu_result;
        else if (wb_rf_write && (wb_addr == src_idx[gi]))
          fwd_val[gi] = wb_data;
      end
    end
  endgenerate

  assign hazard_stall = idex_reg.valid && idex_reg.mem_read && idex_reg.reg_write &&
                        (idex_reg.rd_idx != '0) && id_valid &&
                        ((id_rs1_idx == idex_reg.rd_idx) || (id_rs2_idx == idex_reg.rd_idx));

  assign alu_b = idex_reg.alu_src ? idex_reg.imm : fwd_val[1];

  alu16 u_alu (
    .a  (fwd_val[0]),
    .b  (alu_b),
    .op (idex_reg.alu_op),
    .y  (alu_y)
  );

  assign result_next = idex_reg.reg_store ? idex_reg.opcp2 : alu_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_reg      <= IDEX_BUBBLE;
      ex_valid      <= 1'b0;
      ex_alu_result <= '0;
      ex_store_data <= '0;
      ex_rd_idx     <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_opcp2      <= '0;
    end else if (!mem_stall) begin
      ex_valid      <= idex_reg.valid;
      ex_alu_result <= result_next;
      ex_store_data <= fwd_val[1];
      ex_rd_idx     <= idex_reg.rd_idx;
      ex_reg_write  <= idex_reg.valid & idex_reg.reg_write;
      ex_mem_write  <= idex_reg.valid & idex_reg.mem_write;
      ex_mem_read   <= idex_reg.valid & idex_reg.mem_read;
      ex_opcp2      <= idex_reg.opcp2;
      // Flush and load-use both squash the incoming instruction into a bubble.
      if (flush || hazard_stall)
        idex_reg <= IDEX_BUBBLE;
      else
        idex_reg <= idex_next;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus random traffic,
// each cycle compared against a transaction-level reference model.
module tb_execute_stage;
  import misc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_reg_write, id_alu_src, id_mem_write, id_mem_read, id_reg_store;
  logic [2:0]  id_alu_op;
  logic [15:0] id_opcp2, id_rs1_val, id_rs2_val, id_imm;
  logic [3:0]  id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic        flush, mem_stall, wb_rf_write;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_write, ex_mem_read;
  logic [15:0] ex_alu_result, ex_store_data, ex_opcp2;
  logic [3:0]  ex_rd_idx;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_mem_write(id_mem_write),
    .id_mem_read(id_mem_read), .id_reg_store(id_reg_store), .id_opcp2(id_opcp2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_rs1_idx(id_rs1_idx),
    .id_rs2_idx(id_rs2_idx), .id_rd_idx(id_rd_idx), .id_imm(id_imm), .flush(flush),
    .mem_stall(mem_stall), .wb_rf_write(wb_rf_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd_idx(ex_rd_idx), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_opcp2(ex_opcp2)
  );

  // Reference model: the instruction waiting to execute and the expected EX/MEM contents.
  typedef struct {
    logic v, rw, src, mw, mr, rs;
    logic [2:0] op;
    logic [15:0] pc, v1, v2, imm;
    logic [3:0] i1, i2, rd;
  } instr_t;

  instr_t      m_id;
  logic        mx_v, mx_rw, mx_mw, mx_mr;
  logic [15:0] mx_res, mx_sd, mx_pc;
  logic [3:0]  mx_rd;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int ua, ub, sh;
    ua = int'(a); ub = int'(b); sh = ub % 16;
    case (op)
      3'd0: return 16'((ua + ub) % 65536);
      3'd1: return 16'((ua - ub + 65536) % 65536);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return 16'((ua * (1 << sh)) % 65536);
      3'd6: return 16'(ua / (1 << sh));
      default: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] m_operand(input logic [3:0] idx, input logic [15:0] val);
    if (idx == 0) return 16'd0;
    if (mx_v && mx_rw && !mx_mr && mx_rd == idx) return mx_res;
    if (wb_rf_write && wb_addr == idx) return wb_data;
    return val;
  endfunction

  function automatic logic m_hazard();
    return m_id.v && m_id.mr && m_id.rw && (m_id.rd != 0) && id_valid &&
           (id_rs1_idx == m_id.rd || id_rs2_idx == m_id.rd);
  endfunction

  function automatic logic [63:0] ex_bundle();
    return {8'd0, ex_valid, ex_reg_write, ex_mem_write, ex_mem_read, ex_rd_idx,
            ex_alu_result, ex_store_data, ex_opcp2};
  endfunction

  task automatic model_clear();
    m_id = '{default: '0};
    mx_v = 0; mx_rw = 0; mx_mw = 0; mx_mr = 0; mx_res = 0; mx_sd = 0; mx_pc = 0; mx_rd = 0;
  endtask

  // One clock: check the stall request, advance the model, then check EX/MEM.
  task automatic cycle(input string what);
    logic hz;
    logic [15:0] a, b;
    #1;
    hz = m_hazard();
    check({what, "/hazard"}, 64'(hazard_stall), 64'(hz));
    if (reset) model_clear();
    else if (!mem_stall) begin
      a = m_operand(m_id.i1, m_id.v1);
      b = m_operand(m_id.i2, m_id.v2);
      mx_res = m_id.rs ? m_id.pc : ref_alu(m_id.op, a, m_id.src ? m_id.imm : b);
      mx_sd = b; mx_v = m_id.v; mx_rd = m_id.rd; mx_pc = m_id.pc;
      mx_rw = m_id.v & m_id.rw; mx_mw = m_id.v & m_id.mw; mx_mr = m_id.v & m_id.mr;
      if (flush || hz) m_id = '{default: '0};
      else m_id = '{v: id_valid, rw: id_reg_write, src: id_alu_src, mw: id_mem_write,
                    mr: id_mem_read, rs: id_reg_store, op: id_alu_op, pc: id_opcp2,
                    v1: id_rs1_val, v2: id_rs2_val, imm: id_imm, i1: id_rs1_idx,
                    i2: id_rs2_idx, rd: id_rd_idx};
    end
    @(posedge clk); #1;
    check({what, "/ex"}, ex_bundle(),
          {8'd0, mx_v, mx_rw, mx_mw, mx_mr, mx_rd, mx_res, mx_sd, mx_pc});
    $display("%-10s rst=%0b fl=%0b ms=%0b hz=%0b -> ex_v=%0b rd=%0d res=0x%04h sd=0x%04h",
             what, reset, flush, mem_stall, hz, ex_valid, ex_rd_idx, ex_alu_result, ex_store_data);
  endtask

  task automatic present(input logic v, rw, src, input logic [2:0] op, input logic mw, mr, rs,
                         input logic [15:0] pc, v1, v2, input logic [3:0] i1, i2, rd,
                         input logic [15:0] imm);
    id_valid = v; id_reg_write = rw; id_alu_src = src; id_alu_op = op;
    id_mem_write = mw; id_mem_read = mr; id_reg_store = rs; id_opcp2 = pc;
    id_rs1_val = v1; id_rs2_val = v2; id_rs1_idx = i1; id_rs2_idx = i2;
    id_rd_idx = rd; id_imm = imm;
  endtask

  task automatic idle();
    present(0, 0, 0, 3'd0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0, 16'h0);
  endtask

  initial begin
    reset = 1; flush = 0; mem_stall = 0; wb_rf_write = 0; wb_addr = 0; wb_data = 0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    cycle("reset");
    check("reset_valid", 64'(ex_valid), 64'd0);
    check("reset_hazard", 64'(hazard_stall), 64'd0);
    reset = 0;

    // ADD r3 = r1(5) + r2(7)
    present(1, 1, 0, ALU_ADD, 0, 0, 0, 16'h0010, 16'd5, 16'd7, 4'd1, 4'd2, 4'd3, 16'h0);
    cycle("add");
    idle(); cycle("idle");
    check("add_result", 64'(ex_alu_result), 64'd12);
    check("add_rd", 64'(ex_rd_idx), 64'd3);
    check("add_valid_rw", 64'({ex_valid, ex_reg_write}), 64'b11);

    // ADDI r1 = 0x7FFF then ADD r2 = r1 + r1 with stale operands
    present(1, 1, 1, ALU_ADD, 0, 0, 0, 16'h0020, 16'd0, 16'd0, 4'd0, 4'd0, 4'd1, 16'h7FFF);
    cycle("addi");
    present(1, 1, 0, ALU_ADD, 0, 0, 0, 16'h0022, 16'd0, 16'd0, 4'd1, 4'd1, 4'd2, 16'h0);
    cycle("add_dep");
    idle(); cycle("idle");
    check("fwd_exmem", 64'(ex_alu_result), 64'hFFFE);
    // Same pair with r0 as destination: nothing to forward
    present(1, 1, 1, ALU_ADD, 0, 0, 0, 16'h0030, 16'd0, 16'd0, 4'd0, 4'd0, 4'd0, 16'h7FFF);
    cycle("addi_r0");
    present(1, 1, 0, ALU_ADD, 0, 0, 0, 16'h0032, 16'd0, 16'd0, 4'd1, 4'd1, 4'd2, 16'h0);
    cycle("add_dep0");
    idle(); cycle("idle");
    check("no_fwd_r0", 64'(ex_alu_result), 64'd0);

    // Load-use: LW r4 then ADD r5 = r4 + r4
    present(1, 1, 1, ALU_ADD, 0, 1, 0, 16'h0040, 16'd0, 16'd0, 4'd0, 4'd0, 4'd4, 16'h0100);
    cycle("lw");
    present(1, 1, 0, ALU_ADD, 0, 0, 0, 16'h0042, 16'd0, 16'd0, 4'd4, 4'd4, 4'd5, 16'h0);
    #1 check("lu_stall_on", 64'(hazard_stall), 64'd1);
    cycle("lu_stall");
    #1 check("lu_stall_once", 64'(hazard_stall), 64'd0);
    cycle("lu_retry");
    check("lu_bubble", 64'({ex_valid, ex_reg_write, ex_mem_read}), 64'd0);
    idle(); wb_rf_write = 1; wb_addr = 4'd4; wb_data = 16'd9;
    cycle("lu_wb");
    check("lu_wb_fwd", 64'(ex_alu_result), 64'd18);
    wb_rf_write = 0;

    // mem_stall with SUB 3-5 in EX/MEM and SLT 3,5 in ID/EX
    idle(); cycle("idle"); cycle("idle");
    present(1, 1, 0, ALU_SUB, 0, 0, 0, 16'h0050, 16'd3, 16'd5, 4'd1, 4'd2, 4'd6, 16'h0);
    cycle("sub");
    present(1, 1, 0, ALU_SLT, 0, 0, 0, 16'h0052, 16'd3, 16'd5, 4'd1, 4'd2, 4'd7, 16'h0);
    cycle("slt");
    check("sub_result", 64'(ex_alu_result), 64'hFFFE);
    idle(); mem_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle("mstall");
      check("mstall_frozen", 64'({ex_rd_idx, ex_alu_result}), 64'({4'd6, 16'hFFFE}));
    end
    mem_stall = 0;
    cycle("release");
    check("slt_result", 64'(ex_alu_result), 64'd1);

    // flush a JAL, then let one through with its link value
    present(1, 1, 0, ALU_ADD, 0, 0, 1, 16'h0042, 16'd0, 16'd0, 4'd0, 4'd0, 4'd7, 16'h0);
    flush = 1; cycle("jal_flush");
    flush = 0; idle(); cycle("idle");
    check("flush_bubble", 64'({ex_valid, ex_reg_write}), 64'd0);
    present(1, 1, 0, ALU_ADD, 0, 0, 1, 16'h0042, 16'd0, 16'd0, 4'd0, 4'd0, 4'd7, 16'h0);
    cycle("jal");
    idle(); cycle("idle");
    check("link_value", 64'(ex_alu_result), 64'h0042);

    // reset while a load-use stall is being requested
    present(1, 1, 1, ALU_ADD, 0, 1, 0, 16'h0060, 16'd0, 16'd0, 4'd0, 4'd0, 4'd4, 16'h0200);
    cycle("lw");
    present(1, 1, 0, ALU_ADD, 0, 0, 0, 16'h0062, 16'd0, 16'd0, 4'd4, 4'd4, 4'd5, 16'h0);
    #1 check("rst_hz_pre", 64'(hazard_stall), 64'd1);
    reset = 1; cycle("rst_hz");
    check("rst_hz_ex", ex_bundle(), 64'd0);
    check("rst_hz_stall", 64'(hazard_stall), 64'd0);
    reset = 0;
    present(1, 1, 0, ALU_ADD, 0, 0, 0, 16'h0070, 16'd5, 16'd7, 4'd1, 4'd2, 4'd3, 16'h0);
    cycle("add");
    idle(); cycle("idle");
    check("resume_add", 64'(ex_alu_result), 64'd12);

    // Random traffic over a small register window to provoke forwarding and hazards
    for (int t = 0; t < 300; t++) begin
      reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0)
        present(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom), 16'($urandom),
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                16'($urandom));
      else idle();
      flush = ($urandom_range(0, 9) == 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      wb_rf_write = 1'($urandom_range(0, 1));
      wb_addr = 4'($urandom_range(0, 3));
      wb_data = 16'($urandom);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
